// File: rtl/serv_sysdec_if.sv
// serv_sysdec_if: groups the fetch/execute handshake and the decode result
// bundle of serv_sysdec.
//   Fetch side : i_wb_rdt (instr[31:2]), i_wb_en (accept strobe)
//   Execute    : i_cnt_done (instruction complete)
//   Debug/IRQ  : i_dbg_halt, i_dbg_step, i_irq_pending
//   Decode out : o_csr_en, o_csr_addr, o_csr_int_en, o_csr_source, o_csr_imm_en,
//                o_ecall, o_ebreak, o_mret, o_dret, o_illegal
//   Control out: o_wfi_stall, o_dbg_mode, o_dbg_delay, o_dbg_cause
// Modport slave is the decoder; modport master is the core/driver side.
interface serv_sysdec_if #(
    parameter int CSR_AW = 3
);
    logic [29:0]       i_wb_rdt;
    logic              i_wb_en;
    logic              i_cnt_done;
    logic              i_dbg_halt;
    logic              i_dbg_step;
    logic              i_irq_pending;
    logic              o_csr_en;
    logic [CSR_AW-1:0] o_csr_addr;
    logic [5:0]        o_csr_int_en;
    logic [1:0]        o_csr_source;
    logic              o_csr_imm_en;
    logic              o_ecall;
    logic              o_ebreak;
    logic              o_mret;
    logic              o_dret;
    logic              o_illegal;
    logic              o_wfi_stall;
    logic              o_dbg_mode;
    logic              o_dbg_delay;
    logic [2:0]        o_dbg_cause;

    modport slave (
        input  i_wb_rdt, i_wb_en, i_cnt_done, i_dbg_halt, i_dbg_step, i_irq_pending,
        output o_csr_en, o_csr_addr, o_csr_int_en, o_csr_source, o_csr_imm_en,
               o_ecall, o_ebreak, o_mret, o_dret, o_illegal,
               o_wfi_stall, o_dbg_mode, o_dbg_delay, o_dbg_cause
    );

    modport master (
        output i_wb_rdt, i_wb_en, i_cnt_done, i_dbg_halt, i_dbg_step, i_irq_pending,
        input  o_csr_en, o_csr_addr, o_csr_int_en, o_csr_source, o_csr_imm_en,
               o_ecall, o_ebreak, o_mret, o_dret, o_illegal,
               o_wfi_stall, o_dbg_mode, o_dbg_delay, o_dbg_cause
    );
endinterface

// File: rtl/serv_sysdec.sv
// serv_sysdec: SYSTEM-opcode / CSR decoder with debug entry/exit FSM and WFI
// stall for the bit-serial core. Instruction fields are latched on fetch;
// all decode outputs are combinational from those fields and the FSM state.
// Ports: clk, i_rst (async, active-high), bus (serv_sysdec_if.slave; see the
// interface file for the signal list).
// Parameters: CSR_AW (2 or 3; 2 drops RF debug CSR slots), WITH_DBG, WITH_WFI.
module serv_sysdec #(
    parameter int CSR_AW   = 3,
    parameter int WITH_DBG = 1,
    parameter int WITH_WFI = 1
) (
    input  logic         clk,
    input  logic         i_rst,
    serv_sysdec_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_DEBUG   = 2'd2,
        ST_RESUME  = 2'd3
    } state_t;

    localparam logic [4:0] OP_SYS    = 5'b11100;
    localparam logic [4:0] OP_NOP    = 5'b00100;
    localparam logic       DBG_EN    = 1'(WITH_DBG != 0);
    localparam logic       WFI_EN    = 1'(WITH_WFI != 0);
    localparam state_t     RST_STATE = (WITH_DBG != 0) ? ST_RESUME : ST_RUN;

    state_t      state_q, state_d;
    logic [4:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [11:0] imm_q;
    logic [2:0]  cause_q, cause_d;
    logic        stall_q, stall_d;
    logic        fetched_q, fetched_d;

    logic [4:0]  f_opcode_s;
    logic [2:0]  f_funct3_s;
    logic [11:0] f_imm_s;
    logic        subst_s, f_ebreak_s, f_wfi_s;

    logic        sys_s, priv_s, csr_s, dbg_mode_s;
    logic        ecall_s, ebreak_s, mret_s, dret_s, priv_bad_s;
    logic        rf_hit_s, dbg_csr_s, rf_dbg_s, unknown_s, dbg_blk_s, csr_ok_s;
    logic [2:0]  rf_slot_s;
    logic [5:0]  int_sel_s;
    logic        unused_s;

    // rd/rs1 are not needed here; the main decoder owns them.
    assign unused_s = ^{bus.i_wb_rdt[17:13], bus.i_wb_rdt[9:5], rf_slot_s[2]};

    assign dbg_mode_s = DBG_EN && (state_q == ST_DEBUG);

    // Fetch mux: in RUN a pending halt/step replaces the fetched word with ebreak.
    always_comb begin
        subst_s = DBG_EN && (state_q == ST_RUN) && (bus.i_dbg_halt || bus.i_dbg_step);
        if (subst_s) begin
            f_opcode_s = OP_SYS;
            f_funct3_s = 3'b000;
            f_imm_s    = 12'h001;
        end else begin
            f_opcode_s = bus.i_wb_rdt[4:0];
            f_funct3_s = bus.i_wb_rdt[12:10];
            f_imm_s    = bus.i_wb_rdt[29:18];
        end
        f_ebreak_s = (f_opcode_s == OP_SYS) && (f_funct3_s == 3'b000) && (f_imm_s == 12'h001);
        f_wfi_s    = WFI_EN && (f_opcode_s == OP_SYS) && (f_funct3_s == 3'b000)
                     && (f_imm_s == 12'h105);
    end

    // State, latched instruction fields, debug cause and WFI stall registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= RST_STATE;
            opcode_q  <= OP_NOP;
            funct3_q  <= 3'b000;
            imm_q     <= 12'h000;
            cause_q   <= 3'd0;
            stall_q   <= 1'b0;
            fetched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            stall_q   <= stall_d;
            fetched_q <= fetched_d;
            if (bus.i_wb_en) begin
                opcode_q <= f_opcode_s;
                funct3_q <= f_funct3_s;
                imm_q    <= f_imm_s;
            end
        end
    end

    // Privileged-op decode of the latched immediate (funct3 = 000).
    always_comb begin
        sys_s      = (opcode_q == OP_SYS);
        priv_s     = sys_s && (funct3_q == 3'b000);
        csr_s      = sys_s && (funct3_q != 3'b000);
        ecall_s    = 1'b0;
        ebreak_s   = 1'b0;
        mret_s     = 1'b0;
        dret_s     = 1'b0;
        priv_bad_s = 1'b0;
        case (imm_q)
            12'h000: ecall_s    = 1'b1;
            12'h001: ebreak_s   = 1'b1;
            12'h302: mret_s     = 1'b1;
            12'h7b2: dret_s     = 1'b1;
            12'h105: priv_bad_s = 1'b0;  // wfi: stall is handled at fetch time
            default: priv_bad_s = 1'b1;
        endcase
    end

    // Full 12-bit CSR address table: RF slots, internal one-hot, debug flags.
    always_comb begin
        rf_hit_s  = 1'b0;
        rf_slot_s = 3'd0;
        int_sel_s = 6'd0;
        dbg_csr_s = 1'b0;
        rf_dbg_s  = 1'b0;
        unknown_s = 1'b0;
        case (imm_q)
            12'h340: begin rf_hit_s = 1'b1; rf_slot_s = 3'd0; end
            12'h341: begin rf_hit_s = 1'b1; rf_slot_s = 3'd1; end
            12'h343: begin rf_hit_s = 1'b1; rf_slot_s = 3'd2; end
            12'h305: begin rf_hit_s = 1'b1; rf_slot_s = 3'd3; end
            12'h7b1: begin rf_hit_s = 1'b1; rf_slot_s = 3'd5; dbg_csr_s = 1'b1; rf_dbg_s = 1'b1; end
            12'h7b2: begin rf_hit_s = 1'b1; rf_slot_s = 3'd6; dbg_csr_s = 1'b1; rf_dbg_s = 1'b1; end
            12'h7b3: begin rf_hit_s = 1'b1; rf_slot_s = 3'd7; dbg_csr_s = 1'b1; rf_dbg_s = 1'b1; end
            12'h300: int_sel_s = 6'b000001;
            12'h304: int_sel_s = 6'b000010;
            12'h342: int_sel_s = 6'b000100;
            12'h301: int_sel_s = 6'b001000;
            12'hf14: int_sel_s = 6'b010000;
            12'h7b0: begin int_sel_s = 6'b100000; dbg_csr_s = 1'b1; end
            default: unknown_s = 1'b1;
        endcase
    end

    // Debug CSRs need debug mode; RF debug slots do not exist in a 2-bit RF map.
    assign dbg_blk_s = dbg_csr_s && (!dbg_mode_s || (rf_dbg_s && (CSR_AW == 2)));
    assign csr_ok_s  = csr_s && !unknown_s && !dbg_blk_s;

    // Debug FSM next state, cause capture and RESUME fetch tracking.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        fetched_d = fetched_q;
        case (state_q)
            ST_RUN: begin
                fetched_d = 1'b0;
                if (bus.i_wb_en && subst_s) begin
                    state_d = ST_HALTING;
                    cause_d = bus.i_dbg_step ? 3'd4 : 3'd3;
                end else if (bus.i_wb_en && f_ebreak_s) begin
                    state_d = ST_HALTING;
                    cause_d = 3'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTING: begin
                if (bus.i_cnt_done) state_d = ST_DEBUG;
                else                state_d = ST_HALTING;
            end
            ST_DEBUG: begin
                fetched_d = 1'b0;
                if (priv_s && dret_s && bus.i_cnt_done) state_d = ST_RESUME;
                else                                     state_d = ST_DEBUG;
            end
            ST_RESUME: begin
                // Leave only once an instruction fetched after entry completes.
                if (fetched_q && bus.i_cnt_done) begin
                    state_d   = ST_RUN;
                    fetched_d = 1'b0;
                end else if (bus.i_wb_en) begin
                    fetched_d = 1'b1;
                end else begin
                    fetched_d = fetched_q;
                end
            end
            default: state_d = RST_STATE;
        endcase
        if (!DBG_EN) begin
            state_d   = ST_RUN;
            cause_d   = 3'd0;
            fetched_d = 1'b0;
        end else begin
            fetched_d = fetched_d;
        end
    end

    // WFI stall: a wake source present in the latch cycle wins over setting.
    always_comb begin
        if (bus.i_irq_pending || bus.i_dbg_halt) begin
            stall_d = 1'b0;
        end else if (bus.i_wb_en && f_wfi_s) begin
            stall_d = 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    assign bus.o_csr_en     = csr_ok_s && rf_hit_s;
    assign bus.o_csr_addr   = (csr_ok_s && rf_hit_s) ? rf_slot_s[CSR_AW-1:0] : {CSR_AW{1'b0}};
    assign bus.o_csr_int_en = csr_ok_s ? int_sel_s : 6'd0;
    assign bus.o_csr_source = funct3_q[1:0];
    assign bus.o_csr_imm_en = sys_s && funct3_q[2];
    assign bus.o_ecall      = priv_s && ecall_s;
    assign bus.o_ebreak     = priv_s && ebreak_s;
    assign bus.o_mret       = priv_s && mret_s;
    assign bus.o_dret       = priv_s && dret_s && dbg_mode_s;
    assign bus.o_illegal    = (csr_s && !csr_ok_s)
                              || (priv_s && (priv_bad_s || (dret_s && !dbg_mode_s)));
    assign bus.o_wfi_stall  = stall_q;
    assign bus.o_dbg_mode   = dbg_mode_s;
    assign bus.o_dbg_delay  = DBG_EN && (state_q == ST_RESUME);
    assign bus.o_dbg_cause  = DBG_EN ? cause_q : 3'd0;

endmodule

// File: tb/tb_serv_sysdec.sv
// Bench for serv_sysdec: a decode vector table run in RUN mode through an
// expected-value queue, followed by hand-written debug and WFI sequences.
// Three builds are driven in lockstep: default, CSR_AW=2 and WITH_WFI=0.
module tb_serv_sysdec;

    logic clk;
    logic i_rst;
    int   n_pass;
    int   n_total;

    serv_sysdec_if #(.CSR_AW(3)) bus ();
    serv_sysdec_if #(.CSR_AW(2)) bus_aw2 ();
    serv_sysdec_if #(.CSR_AW(3)) bus_nw ();

    serv_sysdec #(.CSR_AW(3), .WITH_DBG(1), .WITH_WFI(1)) dut     (.clk(clk), .i_rst(i_rst), .bus(bus));
    serv_sysdec #(.CSR_AW(2), .WITH_DBG(1), .WITH_WFI(1)) dut_aw2 (.clk(clk), .i_rst(i_rst), .bus(bus_aw2));
    serv_sysdec #(.CSR_AW(3), .WITH_DBG(1), .WITH_WFI(0)) dut_nw  (.clk(clk), .i_rst(i_rst), .bus(bus_nw));

    assign bus_aw2.i_wb_rdt      = bus.i_wb_rdt;
    assign bus_aw2.i_wb_en       = bus.i_wb_en;
    assign bus_aw2.i_cnt_done    = bus.i_cnt_done;
    assign bus_aw2.i_dbg_halt    = bus.i_dbg_halt;
    assign bus_aw2.i_dbg_step    = bus.i_dbg_step;
    assign bus_aw2.i_irq_pending = bus.i_irq_pending;
    assign bus_nw.i_wb_rdt       = bus.i_wb_rdt;
    assign bus_nw.i_wb_en        = bus.i_wb_en;
    assign bus_nw.i_cnt_done     = bus.i_cnt_done;
    assign bus_nw.i_dbg_halt     = bus.i_dbg_halt;
    assign bus_nw.i_dbg_step     = bus.i_dbg_step;
    assign bus_nw.i_irq_pending  = bus.i_irq_pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [17:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [17:0] exp_q[$];

    localparam logic [31:0] ADDI = 32'h00500093;

    function automatic logic [31:0] sysi(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd2, 7'b1110011};
    endfunction

    // {csr_en, addr[2:0], int_en[5:0], source[1:0], imm_en, ecall, ebreak, mret, dret, illegal}
    function automatic logic [17:0] pk(input logic en, input logic [2:0] ad, input logic [5:0] ie,
                                       input logic [1:0] src, input logic im, input logic [4:0] fl);
        return {en, ad, ie, src, im, fl};
    endfunction

    function automatic logic [17:0] act_main();
        return {bus.o_csr_en, bus.o_csr_addr, bus.o_csr_int_en, bus.o_csr_source,
                bus.o_csr_imm_en, bus.o_ecall, bus.o_ebreak, bus.o_mret, bus.o_dret, bus.o_illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic add(input string n, input logic [31:0] ins, input logic [17:0] e);
        vec_t v;
        v.name = n;
        v.ins  = ins;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the following negedge with the word latched.
    task automatic fetch(input logic [31:0] ins);
        bus.i_wb_rdt = ins[31:2];
        bus.i_wb_en  = 1'b1;
        @(negedge clk);
        bus.i_wb_en  = 1'b0;
    endtask

    task automatic done();
        bus.i_cnt_done = 1'b1;
        @(negedge clk);
        bus.i_cnt_done = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        i_rst   = 1'b1;
        bus.i_wb_rdt      = 30'd0;
        bus.i_wb_en       = 1'b0;
        bus.i_cnt_done    = 1'b0;
        bus.i_dbg_halt    = 1'b0;
        bus.i_dbg_step    = 1'b0;
        bus.i_irq_pending = 1'b0;

        add("csrrw_341",   sysi(12'h341, 3'b001), pk(1'b1, 3'd1, 6'd0,       2'd1, 1'b0, 5'b00000));
        add("csrrs_f14",   sysi(12'hf14, 3'b010), pk(1'b0, 3'd0, 6'b010000,  2'd2, 1'b0, 5'b00000));
        add("csrrw_7b1",   sysi(12'h7b1, 3'b001), pk(1'b0, 3'd0, 6'd0,       2'd1, 1'b0, 5'b00001));
        add("csrrwi_340",  sysi(12'h340, 3'b101), pk(1'b1, 3'd0, 6'd0,       2'd1, 1'b1, 5'b00000));
        add("csrrc_305",   sysi(12'h305, 3'b011), pk(1'b1, 3'd3, 6'd0,       2'd3, 1'b0, 5'b00000));
        add("csrrsi_343",  sysi(12'h343, 3'b110), pk(1'b1, 3'd2, 6'd0,       2'd2, 1'b1, 5'b00000));
        add("csrrs_300",   sysi(12'h300, 3'b010), pk(1'b0, 3'd0, 6'b000001,  2'd2, 1'b0, 5'b00000));
        add("csrrw_304",   sysi(12'h304, 3'b001), pk(1'b0, 3'd0, 6'b000010,  2'd1, 1'b0, 5'b00000));
        add("csrrc_342",   sysi(12'h342, 3'b011), pk(1'b0, 3'd0, 6'b000100,  2'd3, 1'b0, 5'b00000));
        add("csrrs_301",   sysi(12'h301, 3'b010), pk(1'b0, 3'd0, 6'b001000,  2'd2, 1'b0, 5'b00000));
        add("csrrw_7b0",   sysi(12'h7b0, 3'b001), pk(1'b0, 3'd0, 6'd0,       2'd1, 1'b0, 5'b00001));
        add("csrrw_123",   sysi(12'h123, 3'b001), pk(1'b0, 3'd0, 6'd0,       2'd1, 1'b0, 5'b00001));
        add("ecall",       sysi(12'h000, 3'b000), pk(1'b0, 3'd0, 6'd0,       2'd0, 1'b0, 5'b10000));
        add("mret",        sysi(12'h302, 3'b000), pk(1'b0, 3'd0, 6'd0,       2'd0, 1'b0, 5'b00100));
        add("dret_run",    sysi(12'h7b2, 3'b000), pk(1'b0, 3'd0, 6'd0,       2'd0, 1'b0, 5'b00001));
        add("priv_002",    sysi(12'h002, 3'b000), pk(1'b0, 3'd0, 6'd0,       2'd0, 1'b0, 5'b00001));
        add("addi",        ADDI,                  pk(1'b0, 3'd0, 6'd0,       2'd0, 1'b0, 5'b00000));
        add("load_341",    {12'h341, 5'd0, 3'b010, 5'd1, 7'b0000011},
                                                  pk(1'b0, 3'd0, 6'd0,       2'd2, 1'b0, 5'b00000));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_decode", 32'(act_main()), 32'd0);
        chk("rst_delay",  32'(bus.o_dbg_delay), 32'd1);
        chk("rst_mode",   32'(bus.o_dbg_mode), 32'd0);
        chk("rst_stall",  32'(bus.o_wfi_stall), 32'd0);
        chk("rst_cause",  32'(bus.o_dbg_cause), 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // RESUME -> RUN after one fetched instruction completes
        fetch(ADDI);
        chk("resume_hold", 32'(bus.o_dbg_delay), 32'd1);
        done();
        chk("run_delay", 32'(bus.o_dbg_delay), 32'd0);

        // Decode table in RUN
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            fetch(vecs[i].ins);
            chk(vecs[i].name, 32'(act_main()), 32'(exp_q.pop_front()));
            chk({vecs[i].name, "_aw2_ill"}, 32'(bus_aw2.o_illegal), 32'(vecs[i].exp[0]));
        end

        // Halt request: substituted ebreak, then debug mode
        bus.i_dbg_halt = 1'b1;
        fetch(ADDI);
        chk("halt_ebreak", 32'(bus.o_ebreak), 32'd1);
        chk("halt_cause",  32'(bus.o_dbg_cause), 32'd3);
        chk("halting_mode", 32'(bus.o_dbg_mode), 32'd0);
        done();
        chk("debug_mode", 32'(bus.o_dbg_mode), 32'd1);
        fetch(sysi(12'h7b1, 3'b001));
        chk("dbg_7b1", 32'(act_main()), 32'(pk(1'b1, 3'd5, 6'd0, 2'd1, 1'b0, 5'b00000)));
        chk("dbg_7b1_aw2_ill", 32'({bus_aw2.o_illegal, bus_aw2.o_csr_en}), 32'b10);
        fetch(sysi(12'h7b0, 3'b010));
        chk("dbg_7b0", 32'(bus.o_csr_int_en), 32'b100000);
        chk("dbg_halt_ignored", 32'(bus.o_dbg_mode), 32'd1);
        bus.i_dbg_halt = 1'b0;
        fetch(sysi(12'h7b2, 3'b000));
        chk("dret_legal", 32'({bus.o_dret, bus.o_illegal}), 32'b10);
        done();
        chk("dret_exit", 32'({bus.o_dbg_mode, bus.o_dbg_delay}), 32'b01);

        // Single step: one instruction runs, the next fetch halts with cause 4
        bus.i_dbg_step = 1'b1;
        fetch(ADDI);
        chk("step_first_real", 32'(bus.o_ebreak), 32'd0);
        done();
        chk("step_run", 32'({bus.o_dbg_mode, bus.o_dbg_delay}), 32'b00);
        fetch(ADDI);
        chk("step_subst", 32'(bus.o_ebreak), 32'd1);
        chk("step_cause", 32'(bus.o_dbg_cause), 32'd4);
        done();
        chk("step_debug", 32'(bus.o_dbg_mode), 32'd1);
        bus.i_dbg_step = 1'b0;
        fetch(sysi(12'h7b2, 3'b000));
        done();
        fetch(ADDI);
        done();
        chk("back_to_run", 32'({bus.o_dbg_mode, bus.o_dbg_delay}), 32'b00);

        // Genuine ebreak
        fetch(sysi(12'h001, 3'b000));
        chk("ebreak_cause", 32'(bus.o_dbg_cause), 32'd1);
        done();
        chk("ebreak_debug", 32'(bus.o_dbg_mode), 32'd1);
        fetch(sysi(12'h7b2, 3'b000));
        done();
        fetch(ADDI);
        done();

        // WFI stall and wake
        fetch(sysi(12'h105, 3'b000));
        chk("wfi_stall", 32'(bus.o_wfi_stall), 32'd1);
        chk("wfi_legal", 32'(bus.o_illegal), 32'd0);
        chk("nowfi_stall", 32'(bus_nw.o_wfi_stall), 32'd0);
        @(negedge clk);
        chk("wfi_hold", 32'(bus.o_wfi_stall), 32'd1);
        bus.i_irq_pending = 1'b1;
        @(negedge clk);
        bus.i_irq_pending = 1'b0;
        chk("wfi_wake", 32'(bus.o_wfi_stall), 32'd0);
        bus.i_irq_pending = 1'b1;
        fetch(sysi(12'h105, 3'b000));
        bus.i_irq_pending = 1'b0;
        chk("wfi_wake_same_cycle", 32'(bus.o_wfi_stall), 32'd0);

        // Async reset while HALTING with a stall pending
        fetch(sysi(12'h105, 3'b000));
        bus.i_dbg_step = 1'b1;
        fetch(ADDI);
        chk("pre_rst_stall", 32'(bus.o_wfi_stall), 32'd1);
        chk("pre_rst_cause", 32'(bus.o_dbg_cause), 32'd4);
        i_rst = 1'b1;
        #1;
        chk("arst_mode",   32'(bus.o_dbg_mode), 32'd0);
        chk("arst_delay",  32'(bus.o_dbg_delay), 32'd1);
        chk("arst_stall",  32'(bus.o_wfi_stall), 32'd0);
        chk("arst_cause",  32'(bus.o_dbg_cause), 32'd0);
        chk("arst_decode", 32'(act_main()), 32'd0);
        bus.i_dbg_step = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serv_sysdec.md
Name: serv_sysdec

Overview:
- Parametrised SYSTEM-opcode and CSR decoder with an integrated debug-entry/exit state machine for the bit-serial core.
- Latches instruction fields on fetch and decodes the full 12-bit CSR address against a fixed table, rather than a few sparse bits.
- Flags illegal and privileged accesses, implements WFI stalling, and tracks debug halt, single-step and resume.
- Sits beside the main decoder and drives serv_csr, the RF CSR port and the state block.

Parameters:
- CSR_AW, 3, width of external (RF-stored) CSR address. 2 drops the debug CSR slots; legal values are 2 or 3.
- WITH_DBG, 1, enables debug FSM, ebreak substitution and debug CSRs.
- WITH_WFI, 1, enables WFI stall. When 0, WFI decodes as a NOP.

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_wb_rdt  in  30  fetched instruction bits [31:2]
- i_wb_en  in  1  fetch accept strobe; latches fields
- i_cnt_done  in  1  current instruction execution complete
- i_dbg_halt  in  1  debugger halt request (level)
- i_dbg_step  in  1  dcsr.step (level)
- i_irq_pending  in  1  enabled interrupt pending (WFI wake)
- o_csr_en  out  1  access to RF-stored CSR
- o_csr_addr  out  CSR_AW  RF CSR slot
- o_csr_int_en  out  6  one-hot internal CSR: [0]mstatus [1]mie [2]mcause [3]misa [4]mhartid [5]dcsr
- o_csr_source  out  2  funct3[1:0]
- o_csr_imm_en  out  1  CSRRxI form
- o_ecall  out  1  decoded ecall
- o_ebreak  out  1  decoded or substituted ebreak
- o_mret  out  1  decoded mret
- o_dret  out  1  decoded dret, legal only in debug mode
- o_illegal  out  1  unknown CSR, debug CSR/dret outside debug, or unsupported SYSTEM encoding
- o_wfi_stall  out  1  hold fetch
- o_dbg_mode  out  1  core in debug mode
- o_dbg_delay  out  1  one-instruction grace before halt may be taken
- o_dbg_cause  out  3  dcsr.cause: 1 ebreak, 3 haltreq, 4 step

Behaviour:
- **Field latch.** On i_wb_en, capture opcode[6:2], funct3 and imm[31:20].
  - Reset value is NOP: opcode 00100, all other fields 0.
  - All decode outputs are combinational from the latched fields and FSM state.
  - With reset fields, every output is 0 except o_dbg_delay=1.
- **SYS qualifier.** SYS = opcode 11100.
  - Any of o_csr_en, o_csr_int_en, o_csr_imm_en or o_illegal may assert only when SYS.
  - funct3=000 gives privileged ops by imm:
    - 000 ecall
    - 001 ebreak
    - 302 mret
    - 7b2 dret
    - 105 wfi
    - anything else sets o_illegal.
- **CSR map** (SYS, funct3≠0).
  - RF slots: 340→0, 341→1, 343→2, 305→3, 7b1→5, 7b2→6, 7b3→7.
  - Internal: 300, 304, 342, 301, f14, 7b0 map to o_csr_int_en bits 0..5.
  - Unlisted address → o_illegal=1, with o_csr_en and o_csr_int_en both 0.
  - 7b0–7b3 when o_dbg_mode=0, or WITH_DBG=0, or CSR_AW=2 (for 7b1–7b3) → o_illegal.
  - o_csr_imm_en = SYS & funct3[2].
- **Debug FSM** (WITH_DBG=1). States RUN, HALTING, DEBUG, RESUME; reset → RESUME.
  - RUN:
    - If i_wb_en & (i_dbg_halt|i_dbg_step), latch ebreak (opcode 11100, funct3 000, imm 001) instead of i_wb_rdt.
    - Set o_dbg_cause to 4 if i_dbg_step, else 3; go to HALTING.
    - If a genuine ebreak is latched, set cause 1 and go to HALTING.
  - HALTING: on i_cnt_done, go to DEBUG; o_dbg_mode=1 from the next cycle.
  - DEBUG:
    - Substitution is disabled.
    - Latched dret & i_cnt_done → RESUME, o_dbg_mode=0.
    - A halt request is ignored.
  - RESUME:
    - o_dbg_delay=1 and substitution is disabled.
    - The first i_cnt_done after the next i_wb_en → RUN, o_dbg_delay=0.
    - A still-asserted i_dbg_step therefore halts after exactly one instruction.
  - WITH_DBG=0: FSM is held in RUN, o_dbg_* are 0, dret → o_illegal.
- **WFI.**
  - Latching wfi (WITH_WFI=1) sets the o_wfi_stall register the next cycle.
  - Clear on i_irq_pending, on i_dbg_halt, or on reset.
  - If a wake source is present in the latch cycle, the stall is not set.
- **Async reset** mid-instruction: FSM → RESUME, fields → NOP, stall → 0, cause → 0, immediately.

Test Plan:
- Reset, then fetch csrrw x1,0x341 → o_csr_en=1, o_csr_addr=1, o_illegal=0. Then csrrs 0xf14 → o_csr_int_en=010000.
- Fetch csrrw 0x7b1 in RUN → o_illegal=1, o_csr_en=0. Repeat in DEBUG → o_csr_addr=5, o_illegal=0. CSR_AW=2 build → o_illegal=1.
- In RUN, hold i_dbg_halt, fetch addi → o_ebreak=1, cause=3. i_cnt_done → o_dbg_mode=1. Fetch dret + i_cnt_done → RESUME, o_dbg_delay=1.
- i_dbg_step=1 after dret → one instruction executes, then the next fetch is substituted with ebreak, cause=4, back in DEBUG.
- Fetch wfi → o_wfi_stall=1 next cycle. Pulse i_irq_pending → 0 next cycle. WITH_WFI=0 → stall never asserts.
- Assert i_rst during HALTING → immediately o_dbg_mode=0, o_dbg_delay=1, o_wfi_stall=0, decode outputs as NOP.
